// File: rtl/sram_adapter_pkg.sv
// sram_adapter_pkg: shared response type, data-width constants and strobe-to-bit-mask helper
package sram_adapter_pkg;

    localparam int DataWidth  = 64;
    localparam int WidthBytes = DataWidth / 8;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 write;
        logic                 err;
    } rsp_t;

    function automatic logic [DataWidth-1:0] strb_to_mask(input logic [WidthBytes-1:0] strb);
        logic [DataWidth-1:0] m;
        for (int i = 0; i < WidthBytes; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous FIFO of rsp_t with occupancy count
//   clk/rst   clock, synchronous active-high reset
//   push/din  write side (push while full is accepted only together with a pop)
//   pop/dout  read side, dout is the head entry (undefined while empty)
//   count     entries held, empty flag
module sram_rsp_fifo
    import sram_adapter_pkg::*;
#(
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  rsp_t            din,
    input  logic            pop,
    output rsp_t            dout,
    output logic [CntW-1:0] count,
    output logic            empty
);
    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;

    rsp_t            mem [Depth];
    logic [PtrW-1:0] rd;
    logic [PtrW-1:0] wr;
    logic            full;
    logic            do_pop;
    logic            do_push;

    assign empty   = count == '0;
    assign full    = count == CntW'(Depth);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !do_pop));
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr == PtrW'(Depth - 1) ? '0 : wr + 1'b1;
            end
            if (do_pop) rd <= rd == PtrW'(Depth - 1) ? '0 : rd + 1'b1;
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready request channel to single-port SRAM port, registered read data back to a valid/ready response channel
//   clk_i/rst_i                         clock, synchronous active-high reset
//   req_valid_i/req_ready_o + req_*     byte-addressed request with byte strobes
//   rsp_valid_o/rsp_ready_i + rsp_*     in-order response (rdata, write flag, address error)
//   sram_*                              SRAM strobe, write select, word index, data, bit mask, read data
//   SRAM_ADAPTER_ADDR_CHECK_EN          when defined, out-of-window addresses get an error response and no SRAM strobe
module sram_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int                   Width     = DataWidth,
    parameter int                   Depth     = 1 << 15,
    parameter int                   AddrWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = 'h8000_0000,
    parameter int                   RspDepth  = 2,
    localparam int                  Aw        = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [Width-1:0]     req_wdata_i,
    input  logic [Width/8-1:0]   req_wstrb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [Width-1:0]     rsp_rdata_o,
    output logic                 rsp_write_o,
    output logic                 rsp_err_o,
    output logic                 sram_req_o,
    output logic                 sram_write_o,
    output logic [Aw-1:0]        sram_addr_o,
    output logic [Width-1:0]     sram_wdata_o,
    output logic [Width-1:0]     sram_wmask_o,
    input  logic [Width-1:0]     sram_rdata_i
);
    localparam int Off  = $clog2(Width / 8);
    localparam int CntW = $clog2(RspDepth + 1);

    logic                 accept;
    logic                 addr_err;
    logic                 strobe;
    logic [AddrWidth-1:0] offs;
    logic [AddrWidth-1:0] word;
    logic                 unused_bits;
    logic                 inflight;
    logic                 inflight_write;
    logic                 inflight_err;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_empty;
    rsp_t                 new_rsp;
    rsp_t                 head;
    rsp_t                 cur;

    // Credits cover both queued responses and the one whose read data arrives next cycle.
    assign req_ready_o = !rst_i && (int'(fifo_count) + int'(inflight)) < RspDepth;
    assign accept      = req_valid_i && req_ready_o;

    assign offs        = req_addr_i - BaseAddr;
    assign word        = offs >> Off;
    assign unused_bits = ^{word[AddrWidth-1:Aw], offs[Off-1:0]};

`ifdef SRAM_ADAPTER_ADDR_CHECK_EN
    localparam logic [AddrWidth:0] Limit = {1'b0, BaseAddr} + (AddrWidth + 1)'(Depth * (Width / 8));
    assign addr_err = req_addr_i < BaseAddr || {1'b0, req_addr_i} >= Limit;
`else
    assign addr_err = 1'b0;
`endif

    // An erroneous request still takes a credit but never touches the array.
    assign strobe       = accept && !addr_err;
    assign sram_req_o   = strobe;
    assign sram_write_o = strobe && req_write_i;
    assign sram_addr_o  = strobe ? word[Aw-1:0] : '0;
    assign sram_wdata_o = strobe ? req_wdata_i : '0;
    assign sram_wmask_o = strobe ? strb_to_mask(req_wstrb_i) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
            inflight_err   <= 1'b0;
        end else begin
            inflight       <= accept;
            inflight_write <= accept && req_write_i;
            inflight_err   <= accept && addr_err;
        end
    end

    // All fields are zero whenever nothing is in flight, which gives the idle output values.
    always_comb begin
        new_rsp.rdata = (inflight && !inflight_write && !inflight_err) ? sram_rdata_i : '0;
        new_rsp.write = inflight_write;
        new_rsp.err   = inflight_err;
    end

    sram_rsp_fifo #(.Depth(RspDepth)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (inflight && (!fifo_empty || !rsp_ready_i)),
        .din   (new_rsp),
        .pop   (!fifo_empty && rsp_ready_i),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign cur         = fifo_empty ? new_rsp : head;
    assign rsp_valid_o = !fifo_empty || inflight;
    assign rsp_rdata_o = cur.rdata;
    assign rsp_write_o = cur.write;
    assign rsp_err_o   = cur.err;

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: directed self-checking bench for sram_req_adapter with a behavioural SRAM
module tb_sram_req_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;
    logic        sram_req;
    logic        sram_write;
    logic [14:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_wmask;
    logic [63:0] sram_rdata = '0;
    logic [63:0] mem [1 << 15];

    int n_run = 0;
    int n_fail = 0;

    localparam logic [63:0] Tag = 64'hC0DE_0000_0000_0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_write) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else sram_rdata <= mem[sram_addr];
        end
    end

    sram_req_adapter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_write_o  (rsp_write),
        .rsp_err_o    (rsp_err),
        .sram_req_o   (sram_req),
        .sram_write_o (sram_write),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wmask_o (sram_wmask),
        .sram_rdata_i (sram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        #1;
    endtask

    task automatic idle;
        drv(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < (1 << 15); i++) mem[i] = Tag | 64'(i);
        repeat (3) tick;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // full write then read back
        drv(1'b1, 1'b1, 64'h8000_0010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        chk("wr_sram_req", 64'(sram_req), 64'd1);
        chk("wr_sram_write", 64'(sram_write), 64'd1);
        chk("wr_sram_addr", 64'(sram_addr), 64'd2);
        chk("wr_sram_wmask", sram_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
        tick;
        idle;
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_write", 64'(rsp_write), 64'd1);
        chk("wr_rsp_rdata", rsp_rdata, 64'd0);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0010, '0, '0);
        chk("rd_sram_write", 64'(sram_write), 64'd0);
        chk("rd_sram_addr", 64'(sram_addr), 64'd2);
        tick;
        idle;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("rd_rsp_err", 64'(rsp_err), 64'd0);
        chk("rd_rsp_write", 64'(rsp_write), 64'd0);
        tick;
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // partial strobe
        drv(1'b1, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F);
        chk("part_wmask", sram_wmask, 64'h0000_0000_FFFF_FFFF);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0014, '0, '0);
        chk("part_wr_rsp_write", 64'(rsp_write), 64'd1);
        chk("part_rd_addr", 64'(sram_addr), 64'd2);
        tick;
        idle;
        chk("part_rd_rdata", rsp_rdata, 64'hDEADBEEF_5566_7788);

        // backpressure: only two of four reads get in
        tick;
        rsp_ready = 1'b0;
        drv(1'b1, 1'b0, 64'h8000_0000, '0, '0);
        chk("bp_ready0", 64'(req_ready), 64'd1);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0008, '0, '0);
        chk("bp_ready1", 64'(req_ready), 64'd1);
        chk("bp_bypass_rdata", rsp_rdata, Tag | 64'd0);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0020, '0, '0);
        chk("bp_ready2", 64'(req_ready), 64'd0);
        chk("bp_no_strobe2", 64'(sram_req), 64'd0);
        chk("bp_head_rdata", rsp_rdata, Tag | 64'd0);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0028, '0, '0);
        chk("bp_ready3", 64'(req_ready), 64'd0);
        chk("bp_no_strobe3", 64'(sram_req), 64'd0);
        tick;
        chk("bp_still_blocked", 64'(req_ready), 64'd0);
        idle;
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_valid0", 64'(rsp_valid), 64'd1);
        chk("bp_rel_rdata0", rsp_rdata, Tag | 64'd0);
        tick;
        chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
        chk("bp_rel_valid1", 64'(rsp_valid), 64'd1);
        chk("bp_rel_rdata1", rsp_rdata, Tag | 64'd1);
        tick;
        chk("bp_drained", 64'(rsp_valid), 64'd0);

        // streaming: one read per cycle, response one cycle later
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 1'b0, 64'h8000_0000 + 64'(8 * (16 + i)), '0, '0);
            chk("str_ready", 64'(req_ready), 64'd1);
            if (i > 0) chk("str_rdata", rsp_rdata, Tag | 64'(15 + i));
            tick;
        end
        idle;
        chk("str_last_valid", 64'(rsp_valid), 64'd1);
        chk("str_last_rdata", rsp_rdata, Tag | 64'd31);
        tick;
        chk("str_done", 64'(rsp_valid), 64'd0);

        // below-window address
        drv(1'b1, 1'b0, 64'h7FFF_FFF8, '0, '0);
`ifdef SRAM_ADAPTER_ADDR_CHECK_EN
        chk("err_no_strobe", 64'(sram_req), 64'd0);
        tick;
        idle;
        chk("err_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("err_rsp_err", 64'(rsp_err), 64'd1);
        chk("err_rsp_rdata", rsp_rdata, 64'd0);
`else
        chk("wrap_strobe", 64'(sram_req), 64'd1);
        chk("wrap_addr", 64'(sram_addr), 64'h7FFF);
        tick;
        idle;
        chk("wrap_rsp_err", 64'(rsp_err), 64'd0);
        chk("wrap_rsp_rdata", rsp_rdata, Tag | 64'h7FFF);
`endif
        tick;

        // reset with two responses pending
        rsp_ready = 1'b0;
        drv(1'b1, 1'b0, 64'h8000_0080, '0, '0);
        tick;
        drv(1'b1, 1'b0, 64'h8000_0088, '0, '0);
        tick;
        idle;
        chk("mid_pending_valid", 64'(rsp_valid), 64'd1);
        chk("mid_full_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("mid_post_valid", 64'(rsp_valid), 64'd0);
        chk("mid_post_ready", 64'(req_ready), 64'd1);
        chk("mid_post_rdata", rsp_rdata, 64'd0);
        tick;
        chk("mid_stays_empty", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
